mult_seq_ctrl: RTL

- Sequencer for the P01 shift-add multiplier datapath.
- Takes a start request and drives the operand load strobe (l_s), the shift hold (permit) and the accumulate enable (add_en) for the multiplicand left-shift register, the multiplier right-shift register and the accumulator.
- Counts shift steps, supports early termination when the remaining multiplier is zero, and reports completion to the top-level FSM with a one-cycle done pulse.

---
 rtl/mult_seq_ctrl_if.sv | 28 ++
 rtl/mult_seq_ctrl.sv | 91 +++++++++
 2 files changed

// File: rtl/mult_seq_ctrl_if.sv
// rtl/mult_seq_ctrl_if.sv - start/status and datapath control bundle for the shift-add multiplier sequencer
interface mult_seq_ctrl_if #(
  parameter int DW = 16
);
  localparam int CW = $clog2(DW);

  logic          start;
  logic          mplr_lsb;
  logic          mplr_zero;
  logic          ready;
  logic          busy;
  logic          l_s;
  logic          permit;
  logic          add_en;
  logic          done;
  logic          start_err;
  logic [CW-1:0] step;

  modport master (
    output start, mplr_lsb, mplr_zero,
    input  ready, busy, l_s, permit, add_en, done, start_err, step
  );

  modport slave (
    input  start, mplr_lsb, mplr_zero,
    output ready, busy, l_s, permit, add_en, done, start_err, step
  );
endinterface

// File: rtl/mult_seq_ctrl.sv
// rtl/mult_seq_ctrl.sv - sequencer driving load, shift-hold and accumulate strobes of the shift-add multiplier
module mult_seq_ctrl #(
  parameter  int DW = 16,
  localparam int CW = $clog2(DW)
) (
  input  logic          clk,
  input  logic          rst,
  mult_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] step_q, step_d;
  logic          start_err_q;
  logic          last_step;

  logic          ready_c, busy_c, l_s_c, permit_c, add_en_c, done_c;

  assign last_step = (step_q == CW'(DW - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      step_q      <= '0;
      start_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      // Any start seen outside IDLE is flagged; it is never queued.
      start_err_q <= bus.start && (state_q != S_IDLE);
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    ready_c  = 1'b0;
    busy_c   = 1'b0;
    l_s_c    = 1'b0;
    permit_c = 1'b1;
    add_en_c = 1'b0;
    done_c   = 1'b0;

    case (state_q)
      S_IDLE: begin
        ready_c = 1'b1;
        if (bus.start) state_d = S_LOAD;
      end
      S_LOAD: begin
        busy_c  = 1'b1;
        l_s_c   = 1'b1;
        step_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        busy_c   = 1'b1;
        permit_c = 1'b0;
        add_en_c = bus.mplr_lsb;
        // Step freezes on the exit cycle so the counter never passes DW-1.
        if (last_step || bus.mplr_zero) begin
          state_d = S_DONE;
        end else begin
          step_d = step_q + 1'b1;
        end
      end
      S_DONE: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.ready     = ready_c;
  assign bus.busy      = busy_c;
  assign bus.l_s       = l_s_c;
  assign bus.permit    = permit_c;
  assign bus.add_en    = add_en_c;
  assign bus.done      = done_c;
  assign bus.start_err = start_err_q;
  assign bus.step      = step_q;

endmodule
